// File: rtl/xf_load_sequencer.sv
// xf_load_sequencer: turns the XF register-load word stream (header + N data
// words) into one single-cycle write per data word at auto-incrementing XF
// addresses, routed to the position-matrix CP bus or the generic XF port.
module xf_load_sequencer #(
  parameter logic [15:0] POSMAT_BASE  = 16'h0000,
  parameter int unsigned POSMAT_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wordValid,
  output logic        wordReady,
  input  logic [31:0] wordData,
  output logic [8:0]  CPAddr,
  output logic        CPWrite,
  output logic [31:0] CPWriteData,
  output logic [15:0] xfOtherAddr,
  output logic        xfOtherWrite,
  output logic [31:0] xfOtherData,
  output logic        loadBusy,
  output logic        loadDone
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 9;

  // Window bounds kept one bit wider so a window ending at 0x10000 is representable.
  localparam logic [AW:0] WIN_BASE  = (AW+1)'(POSMAT_BASE);
  localparam logic [AW:0] WIN_WORDS = (AW+1)'(POSMAT_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   remaining_q;
  logic [AW-1:0]   addr_d;
  logic [AW-1:0]   remaining_d;
  logic [AW:0]     win_offset;
  logic            in_window;
  logic            last_word;

  logic [CW-1:0]   cp_addr_q;
  logic            cp_write_q;
  logic [DW-1:0]   cp_data_q;
  logic [AW-1:0]   xf_addr_q;
  logic            xf_write_q;
  logic [DW-1:0]   xf_data_q;
  logic            busy_q;
  logic            done_q;

  // Next address wraps 0xFFFF -> 0x0000; remaining count only decrements mid-load.
  assign addr_d      = AW'(addr_q + 1'b1);
  assign remaining_d = AW'(remaining_q - 1'b1);
  assign last_word   = (remaining_q == '0);

  // An address below the base wraps to a huge offset, so one compare covers both bounds.
  assign win_offset  = AW'(0) + ({1'b0, addr_q} - WIN_BASE);
  assign in_window   = (win_offset < WIN_WORDS);

  // The sequencer never stalls; it only refuses words while reset is held.
  assign wordReady   = ~reset;

  // Load FSM plus registered write ports and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      cp_addr_q   <= '0;
      cp_write_q  <= 1'b0;
      cp_data_q   <= '0;
      xf_addr_q   <= '0;
      xf_write_q  <= 1'b0;
      xf_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cp_write_q <= 1'b0;
      xf_write_q <= 1'b0;
      done_q     <= 1'b0;
      if (wordValid) begin
        case (state_q)
          IDLE: begin
            addr_q      <= wordData[15:0];
            remaining_q <= wordData[31:16];
            state_q     <= DATA;
            busy_q      <= 1'b1;
          end
          DATA: begin
            if (in_window) begin
              cp_write_q <= 1'b1;
              cp_addr_q  <= win_offset[CW-1:0];
              cp_data_q  <= wordData;
            end else begin
              xf_write_q <= 1'b1;
              xf_addr_q  <= addr_q;
              xf_data_q  <= wordData;
            end
            addr_q <= addr_d;
            if (last_word) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              remaining_q <= remaining_d;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign CPAddr       = cp_addr_q;
  assign CPWrite      = cp_write_q;
  assign CPWriteData  = cp_data_q;
  assign xfOtherAddr  = xf_addr_q;
  assign xfOtherWrite = xf_write_q;
  assign xfOtherData  = xf_data_q;
  assign loadBusy     = busy_q;
  assign loadDone     = done_q;

endmodule

// File: doc/xf_load_sequencer.md
# xf_load_sequencer

Upstream feeder for the XF position matrix memory. Consumes the 32-bit word stream of XF register-load commands (header word followed by N data words) from the GX command processor. Generates one single-cycle CP-bus write per data word at auto-incrementing XF addresses. Words inside the position-matrix window go out on the CP bus; all other words go out on a generic XF write port.

## Interface
Parameters:
- POSMAT_BASE, 16'h0000, first XF address of the position-matrix window.
- POSMAT_WORDS, 256, window size in words; CPAddr = (xfAddr - POSMAT_BASE)[8:0].

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- wordValid  in  1  upstream word present this cycle.
- wordReady  out  1  block accepts word; transfer when wordValid & wordReady.
- wordData  in  32  header or data word.
- CPAddr  out  9  position-matrix word address.
- CPWrite  out  1  one-cycle write strobe to position matrix.
- CPWriteData  out  32  write data.
- xfOtherAddr  out  16  XF address for non-posmat writes.
- xfOtherWrite  out  1  one-cycle write strobe, non-posmat target.
- xfOtherData  out  32  write data, non-posmat target.
- loadBusy  out  1  high while in DATA state.
- loadDone  out  1  one-cycle pulse after last data word written.

## Operation
- Header format: wordData[31:16] = count-1 (1..65536 words), wordData[15:0] = start XF address.
- FSM states: IDLE, DATA.
- IDLE: accepted word is a header; latch addr <= wordData[15:0], remaining <= wordData[31:16]; go DATA. No write issued for the header.
- DATA: each accepted word issues exactly one write at addr; addr <= addr + 1 (16-bit, wraps 16'hFFFF -> 16'h0000); if remaining == 0 go IDLE and pulse loadDone, else remaining <= remaining - 1.
- Routing per word: POSMAT_BASE <= addr < POSMAT_BASE + POSMAT_WORDS -> CP bus (CPWrite); otherwise -> xfOther port. Routing is decided per word, so a load crossing the window edge splits between ports.
- Never both CPWrite and xfOtherWrite in the same cycle.
- wordReady = 1 in both states when not in reset; block never stalls (position matrix write always completes in one cycle).
- wordValid low: no state change, no write; counter and address held.
- loadBusy = (state == DATA).

## Timing
- All outputs registered. Write strobe, address and data appear the cycle after the accepting edge (latency 1).
- Back-to-back data words give back-to-back writes, one per cycle, no bubbles.
- loadDone asserts in the same cycle as the final write strobe; loadBusy low from that same cycle.
- A header accepted the cycle after a load's last data word is legal; its first data word may follow the next cycle.
- Reset values: state IDLE, wordReady 0 during the reset cycle, CPWrite 0, xfOtherWrite 0, loadDone 0, loadBusy 0, CPAddr 0, CPWriteData 0, xfOtherAddr 0, xfOtherData 0, internal addr/remaining 0.
- Reset mid-load: load abandoned, no further writes; the next accepted word after reset is treated as a header.
- The strobe registered before reset is not cancelled retroactively. Reset in cycle N forces strobes low from cycle N+1.

## Test plan
- Header 32'h0003_0010, data D0..D3 consecutive -> CPWrite at CPAddr 0x010..0x013 on four consecutive cycles with D0..D3; loadDone with 0x013 write; loadBusy falls then.
- Header 32'h0000_1000, one data word 32'hDEADBEEF -> xfOtherWrite with xfOtherAddr 0x1000, data 0xDEADBEEF; CPWrite never asserts; loadDone pulses.
- Header 32'h0003_00FE -> CP writes at 0x0FE and 0x0FF, then xfOther writes at 0x0100 and 0x0101.
- Header 32'h0001_FFFF with wordValid gaps between data words -> xfOther write at 0xFFFF, then CP write at CPAddr 0x000; no write during gap cycles.
- Reset asserted after 2 of 4 data words -> no writes after reset; next word 32'h0000_0020 treated as header; following data word written to CPAddr 0x020.
- Header 32'hFFFF_0000 streamed with 65536 data words -> exactly 65536 writes (256 CP, remainder xfOther); single loadDone at the last write.
